// File: rtl/cpu_mon_pkg.sv
// Shared types and default parameters for the cpu3 run-control monitor.
package cpu_mon_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RUN     = 3'd1,
    ST_HALTED  = 3'd2,
    ST_FAULT   = 3'd3,
    ST_TIMEOUT = 3'd4
  } mon_state_t;

  localparam int unsigned DEF_CNT_W       = 32;
  localparam int unsigned DEF_PC_W        = 32;
  localparam int unsigned DEF_TRACE_DEPTH = 16;
  localparam int unsigned DEF_WDOG_CYCLES = 1024;

  // Run has ended and the monitor is frozen until clear/reset.
  function automatic logic is_terminal(mon_state_t s);
    return (s == ST_HALTED) || (s == ST_FAULT) || (s == ST_TIMEOUT);
  endfunction

endpackage

// File: rtl/cpu_mon_if.sv
// Core-side status signals observed by the run monitor.
interface cpu_mon_if #(
  parameter int unsigned PC_W = 32
) ();

  logic            halt;
  logic            exception;
  logic            retire;
  logic [PC_W-1:0] retire_pc;

  modport master (output halt, output exception, output retire, output retire_pc);
  modport slave  (input  halt, input  exception, input  retire, input  retire_pc);

endinterface

// File: rtl/cpu_mon_trace_buf.sv
// Circular buffer of the most recent retired PCs with a registered read port.
module cpu_mon_trace_buf #(
  parameter int unsigned PC_W        = 32,
  parameter int unsigned TRACE_DEPTH = 16
) (
  input  logic                           clk,
  input  logic                           rst_,
  input  logic                           clear,
  input  logic                           wr_en,
  input  logic [PC_W-1:0]                wr_pc,
  input  logic [$clog2(TRACE_DEPTH)-1:0] rd_idx,
  output logic [$clog2(TRACE_DEPTH):0]   valid_cnt,
  output logic [PC_W-1:0]                rdata
);

  localparam int unsigned IDX_W = $clog2(TRACE_DEPTH);
  localparam int unsigned VC_W  = IDX_W + 1;
  localparam logic [VC_W-1:0] VC_FULL = VC_W'(TRACE_DEPTH);

  logic [PC_W-1:0]  mem [TRACE_DEPTH];
  logic [IDX_W-1:0] wptr_q, wptr_d;
  logic [VC_W-1:0]  vcnt_q, vcnt_d;
  logic [PC_W-1:0]  rdata_q, rdata_d;
  logic [IDX_W-1:0] rd_addr;

  // PC storage; contents are never cleared, validity is tracked by vcnt.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wptr_q] <= wr_pc;
  end

  // Pointer, valid count and read-data next-state.
  always_comb begin
    wptr_d  = wptr_q;
    vcnt_d  = vcnt_q;
    rd_addr = wptr_q - IDX_W'(1) - rd_idx;
    rdata_d = ({1'b0, rd_idx} < vcnt_q) ? mem[rd_addr] : '0;
    if (clear) begin
      wptr_d = '0;
      vcnt_d = '0;
    end else if (wr_en) begin
      wptr_d = wptr_q + IDX_W'(1);
      vcnt_d = (vcnt_q == VC_FULL) ? vcnt_q : vcnt_q + VC_W'(1);
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      wptr_q  <= '0;
      vcnt_q  <= '0;
      rdata_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      vcnt_q  <= vcnt_d;
      rdata_q <= rdata_d;
    end
  end

  assign valid_cnt = vcnt_q;
  assign rdata     = rdata_q;

endmodule

// File: rtl/cpu_run_monitor.sv
// Run-control FSM, cycle/retire counters, watchdog and fault capture for cpu3.
module cpu_run_monitor
  import cpu_mon_pkg::*;
#(
  parameter int unsigned CNT_W       = DEF_CNT_W,
  parameter int unsigned PC_W        = DEF_PC_W,
  parameter int unsigned TRACE_DEPTH = DEF_TRACE_DEPTH,
  parameter int unsigned WDOG_CYCLES = DEF_WDOG_CYCLES
) (
  input  logic                           clk,
  input  logic                           rst_,
  input  logic                           start,
  input  logic                           clear,
  cpu_mon_if.slave                       core,
  input  logic [$clog2(TRACE_DEPTH)-1:0] trc_rd_idx,
  output mon_state_t                     state,
  output logic                           done,
  output logic [CNT_W-1:0]               cycle_count,
  output logic [CNT_W-1:0]               instr_count,
  output logic [CNT_W-1:0]               fault_cycle,
  output logic [PC_W-1:0]                fault_pc,
  output logic [$clog2(TRACE_DEPTH):0]   trc_valid_cnt,
  output logic [PC_W-1:0]                trc_rdata
);

  localparam int unsigned WD_W = $clog2(WDOG_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(WDOG_CYCLES - 1);

  mon_state_t       state_q, state_d;
  logic             done_q, done_d;
  logic [CNT_W-1:0] cycle_q, cycle_d;
  logic [CNT_W-1:0] instr_q, instr_d;
  logic [CNT_W-1:0] fcyc_q, fcyc_d;
  logic [PC_W-1:0]  fpc_q, fpc_d;
  logic [PC_W-1:0]  last_pc_q, last_pc_d;
  logic [WD_W-1:0]  wdog_q, wdog_d;
  logic             trc_we_c;

  // Next-state: clear dominates, then FSM with halt > exception > watchdog.
  always_comb begin
    state_d   = state_q;
    cycle_d   = cycle_q;
    instr_d   = instr_q;
    fcyc_d    = fcyc_q;
    fpc_d     = fpc_q;
    last_pc_d = last_pc_q;
    wdog_d    = wdog_q;
    trc_we_c  = 1'b0;
    if (clear) begin
      state_d   = ST_IDLE;
      cycle_d   = '0;
      instr_d   = '0;
      fcyc_d    = '0;
      fpc_d     = '0;
      last_pc_d = '0;
      wdog_d    = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_d = ST_RUN;
            wdog_d  = '0;
          end
        end
        ST_RUN: begin
          cycle_d = (cycle_q == CNT_MAX) ? cycle_q : cycle_q + CNT_W'(1);
          if (core.retire) begin
            instr_d   = (instr_q == CNT_MAX) ? instr_q : instr_q + CNT_W'(1);
            last_pc_d = core.retire_pc;
            wdog_d    = '0;
            trc_we_c  = 1'b1;
          end else begin
            wdog_d = wdog_q + WD_W'(1);
          end
          if (core.halt) begin
            state_d = ST_HALTED;
          end else if (core.exception) begin
            state_d = ST_FAULT;
          end else if (!core.retire && (wdog_q == WD_LAST)) begin
            state_d = ST_TIMEOUT;
          end
          if (state_d != ST_RUN) begin
            fcyc_d = cycle_d;
            fpc_d  = core.retire ? core.retire_pc : last_pc_q;
          end
        end
        default: ;
      endcase
    end
    done_d = is_terminal(state_d);
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state_q   <= ST_IDLE;
      done_q    <= 1'b0;
      cycle_q   <= '0;
      instr_q   <= '0;
      fcyc_q    <= '0;
      fpc_q     <= '0;
      last_pc_q <= '0;
      wdog_q    <= '0;
    end else begin
      state_q   <= state_d;
      done_q    <= done_d;
      cycle_q   <= cycle_d;
      instr_q   <= instr_d;
      fcyc_q    <= fcyc_d;
      fpc_q     <= fpc_d;
      last_pc_q <= last_pc_d;
      wdog_q    <= wdog_d;
    end
  end

  cpu_mon_trace_buf #(
    .PC_W        (PC_W),
    .TRACE_DEPTH (TRACE_DEPTH)
  ) u_trace (
    .clk       (clk),
    .rst_      (rst_),
    .clear     (clear),
    .wr_en     (trc_we_c),
    .wr_pc     (core.retire_pc),
    .rd_idx    (trc_rd_idx),
    .valid_cnt (trc_valid_cnt),
    .rdata     (trc_rdata)
  );

  assign state       = state_q;
  assign done        = done_q;
  assign cycle_count = cycle_q;
  assign instr_count = instr_q;
  assign fault_cycle = fcyc_q;
  assign fault_pc    = fpc_q;

endmodule
